// File: rtl/gate_quiz_engine.sv
// -----------------------------------------------------------------------------
// gate_quiz_engine
//   Draws pseudo-random operand pairs and a gate opcode from a 16-bit LFSR,
//   presents them as a question, checks the user's answer against the bitwise
//   gate result and keeps a saturating score and streak.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   ena             global enable; low freezes every register
//   start           request a question (level sampled in IDLE)
//   auto_next       issue the next question straight after each result
//   clear           synchronous clear of score/streak, returns to IDLE
//   answer_valid    answer strobe, answer[WIDTH-1:0] is the user's answer
//   question_valid  high while a question is outstanding
//   op_a, op_b      operands of the current question
//   opcode          0 AND,1 OR,2 XOR,3 NAND,4 NOR,5 XNOR,6 NOT A,7 NOT B
//   result_valid    one-cycle result pulse; result_correct qualified by it
//   score, streak   saturating correct-answer and consecutive-correct counts
// -----------------------------------------------------------------------------
module gate_quiz_engine #(
  parameter int          WIDTH   = 2,
  parameter int          SCORE_W = 8,
  parameter int          TIMEOUT = 0,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               start,
  input  logic               auto_next,
  input  logic               clear,
  input  logic               answer_valid,
  input  logic [WIDTH-1:0]   answer,
  output logic               question_valid,
  output logic [WIDTH-1:0]   op_a,
  output logic [WIDTH-1:0]   op_b,
  output logic [2:0]         opcode,
  output logic               result_valid,
  output logic               result_correct,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] streak
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ASK   = 2'd1,
    CHECK = 2'd2
  } state_e;

  // An all-zero seed would lock the LFSR, so it falls back to the default.
  localparam logic [15:0]         SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam int                  CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SCORE_W-1:0]  SAT      = '1;

  state_e             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic [2:0]         opcode_q, opcode_d;
  logic               correct_q, correct_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] streak_q, streak_d;

  logic [WIDTH-1:0]   expected;
  logic               timeout_hit;
  logic               capture;
  logic               done;
  logic               hit;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting right: taps land on
  // bits 0, 2, 3 and 5.
  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  always_comb begin
    expected = '0;
    case (opcode_q)
      3'd0: expected = op_a_q & op_b_q;
      3'd1: expected = op_a_q | op_b_q;
      3'd2: expected = op_a_q ^ op_b_q;
      3'd3: expected = ~(op_a_q & op_b_q);
      3'd4: expected = ~(op_a_q | op_b_q);
      3'd5: expected = ~(op_a_q ^ op_b_q);
      3'd6: expected = ~op_a_q;
      3'd7: expected = ~op_b_q;
      default: expected = '0;
    endcase
  end

  always_comb begin
    timeout_hit = 1'b0;
    if (TIMEOUT > 0) timeout_hit = (32'(cnt_q) == 32'(TIMEOUT - 1));
  end

  // NOTE: every signal gets its hold value first so no path through the
  // case statement leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    opcode_d  = opcode_q;
    correct_d = correct_q;
    score_d   = score_q;
    streak_d  = streak_q;
    capture   = 1'b0;
    done      = 1'b0;
    hit       = 1'b0;

    if (clear) begin
      state_d  = IDLE;
      score_d  = '0;
      streak_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            capture = 1'b1;
            state_d = ASK;
          end
        end
        ASK: begin
          cnt_d = cnt_q + 1'b1;
          // An answer arriving on the expiry cycle still counts.
          if (answer_valid) begin
            done    = 1'b1;
            hit     = (answer == expected);
            state_d = CHECK;
          end else if (timeout_hit) begin
            done    = 1'b1;
            state_d = CHECK;
          end
        end
        CHECK: begin
          if (auto_next) begin
            capture = 1'b1;
            state_d = ASK;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Counters update on the edge into CHECK so they are current with the pulse.
    if (done) begin
      correct_d = hit;
      if (hit) begin
        score_d  = (score_q  == SAT) ? score_q  : score_q  + 1'b1;
        streak_d = (streak_q == SAT) ? streak_q : streak_q + 1'b1;
      end else begin
        streak_d = '0;
      end
    end

    if (capture) begin
      opcode_d = lfsr_q[2:0];
      op_a_d   = lfsr_q[3 +: WIDTH];
      op_b_d   = lfsr_q[3 + WIDTH +: WIDTH];
      cnt_d    = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lfsr_q    <= SEED_EFF;
      cnt_q     <= '0;
      // NOTE: the question registers are reset as well because they drive
      // outputs that must read zero out of reset.
      op_a_q    <= '0;
      op_b_q    <= '0;
      opcode_q  <= '0;
      correct_q <= 1'b0;
      score_q   <= '0;
      streak_q  <= '0;
    end else if (ena) begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      cnt_q     <= cnt_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      opcode_q  <= opcode_d;
      correct_q <= correct_d;
      score_q   <= score_d;
      streak_q  <= streak_d;
    end
  end

  assign question_valid = (state_q == ASK);
  assign result_valid   = (state_q == CHECK);
  assign result_correct = correct_q;
  assign op_a           = op_a_q;
  assign op_b           = op_b_q;
  assign opcode         = opcode_q;
  assign score          = score_q;
  assign streak         = streak_q;

endmodule

// File: doc/gate_quiz_engine.md
Name: gate_quiz_engine

Overview:
Sequential successor to the combinational two-input gate trainer. The block draws pseudo-random WIDTH-bit operand pairs and a gate opcode from an on-chip LFSR and presents them as a question. It then accepts the user's answer, checks it against the bitwise gate result, and keeps a saturating score and streak. It sits behind the tile's ui_in/uo_out/uio pin mapping in the trainer top level.

Parameters:
WIDTH, 2, operand/answer width in bits; legal range 1..6.
SCORE_W, 8, width of the score and streak counters.
TIMEOUT, 0, answer-wait limit in enabled cycles; 0 disables the timeout.
SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'hACE1.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  global enable; when low, all state freezes
start  input  1  request a question (level sampled)
auto_next  input  1  when 1, a new question is issued directly after each result
clear  input  1  synchronous clear of score/streak; FSM returns to IDLE
answer_valid  input  1  answer strobe
answer  input  WIDTH  user's answer
question_valid  output  1  high while a question is outstanding
op_a  output  WIDTH  operand A
op_b  output  WIDTH  operand B
opcode  output  3  0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT A, 7 NOT B
result_valid  output  1  one-cycle result pulse
result_correct  output  1  qualified by result_valid
score  output  SCORE_W  count of correct answers
streak  output  SCORE_W  count of consecutive correct answers

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE, LFSR = SEED, timeout counter = 0.
  - All outputs are 0.
- LFSR:
  - 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
  - Advances one step on every clk edge with ena=1, in every state.
- Question draw, using the LFSR value present at the capturing edge:
  - opcode = lfsr[2:0]
  - op_a = lfsr[3 +: WIDTH]
  - op_b = lfsr[3+WIDTH +: WIDTH]
- Expected result: bitwise gate on op_a/op_b per opcode. NOT A and NOT B ignore the other operand.
- ena=0: no state, LFSR, counter or output changes. start, answer_valid and clear are ignored.
- clear has priority over all other inputs when ena=1. On that edge:
  - score = 0, streak = 0, state = IDLE.
  - question_valid = 0 and result_valid = 0.
- FSM:
  - IDLE:
    - question_valid = 0.
    - start=1 → capture a question and go to ASK. question_valid is high from the next cycle (1-cycle latency).
  - ASK:
    - question_valid = 1; op_a/op_b/opcode are held stable.
    - The timeout counter increments each enabled cycle.
    - answer_valid=1 → latch the compare result and go to CHECK.
    - TIMEOUT>0, counter == TIMEOUT-1 and no answer → go to CHECK with the result forced wrong.
    - answer_valid on the expiry cycle: the answer wins.
    - start is ignored.
  - CHECK (exactly one cycle):
    - result_valid = 1; result_correct = (answer == expected), or 0 on timeout.
    - question_valid = 0.
    - score and streak are updated on the edge entering CHECK, so they are already current while result_valid is high.
    - Next state: auto_next=1 → capture a new question and go to ASK. Otherwise go to IDLE.
    - answer_valid and start are ignored.
- Counter arithmetic:
  - Correct answer: score += 1 and streak += 1, both saturating at 2^SCORE_W-1.
  - Wrong answer or timeout: streak = 0; score unchanged.
- The timeout counter is cleared on every entry to ASK.
- op_a, op_b and opcode retain their last values in IDLE and CHECK.
- Reset asserted mid-ASK or mid-CHECK: immediate return to the reset values. No result pulse is produced.

Test Plan:
- Reset, then start=1 for 1 cycle → question_valid=1 on the next cycle; op_a/op_b/opcode equal the model LFSR slice. Drive the model's correct answer (e.g. op_a=01, op_b=11, opcode=2 → answer=10) → next cycle result_valid=1, result_correct=1, score=1, streak=1, then IDLE.
- Three correct answers then one wrong (e.g. AND of 11,10 answered 11) → score=3, streak=0, result_correct=0 on the 4th pulse.
- SCORE_W=2, auto_next=1, five correct answers → score and streak saturate at 3. A new question is issued every second cycle after each answer.
- TIMEOUT=4, start with no answer → result_valid=1 with result_correct=0 exactly 4 cycles after question_valid rises; streak=0.
- Timeout-expiry cycle with answer_valid=1 and the correct answer → result_correct=1.
- Each of the following:
  - clear during ASK → score=0, streak=0, question_valid=0 next cycle.
  - ena=0 for 5 cycles mid-ASK → all outputs frozen; the timeout does not advance.
  - rst_n pulsed low mid-ASK → all outputs 0 immediately.
- Sweep all 8 opcodes × WIDTH ∈ {1, 6} against the bitwise model.
